// File: rtl/pause_dim_ctrl_if.sv
// Pause/dim control bundle between core-side glue and pause_dim_ctrl.
// master drives requests and video in; slave returns pause and dimmed video.
interface pause_dim_ctrl_if #(
  parameter int NUM_SRC = 2,
  parameter int RW      = 3,
  parameter int GW      = 3,
  parameter int BW      = 2
);
  localparam int CW = RW + GW + BW;

  logic [NUM_SRC-1:0] pause_req;
  logic               user_btn;
  logic               osd_open;
  logic               osd_pause_en;
  logic [CW-1:0]      rgb_in;
  logic [CW-1:0]      rgb_out;
  logic               pause;
  logic               user_paused;
  logic [1:0]         dim_level;

  modport master (
    output pause_req,
    output user_btn,
    output osd_open,
    output osd_pause_en,
    output rgb_in,
    input  rgb_out,
    input  pause,
    input  user_paused,
    input  dim_level
  );

  modport slave (
    input  pause_req,
    input  user_btn,
    input  osd_open,
    input  osd_pause_en,
    input  rgb_in,
    output rgb_out,
    output pause,
    output user_paused,
    output dim_level
  );
endinterface

// File: rtl/pause_dim_ctrl.sv
// Pause combiner with user-pause screen dimming; stepwise fade
// is built only when PAUSE_DIM_FADE_EN is defined.
module pause_dim_ctrl #(
  parameter int NUM_SRC       = 2,
  parameter int DIM_TIMEOUT   = 240000000,
  parameter int FADE_INTERVAL = 1200000,
  parameter int DIM_STEPS     = 2,
  parameter int RW            = 3,
  parameter int GW            = 3,
  parameter int BW            = 2
) (
  input logic             clk,
  input logic             reset,
  pause_dim_ctrl_if.slave bus
);
  localparam int CW = RW + GW + BW;
  localparam int MAXC = (DIM_TIMEOUT > FADE_INTERVAL)
                      ? DIM_TIMEOUT : FADE_INTERVAL;
  localparam int TW = (MAXC > 2) ? $clog2(MAXC) : 1;
  localparam logic [TW-1:0] T_DIM = TW'(DIM_TIMEOUT - 1);
`ifdef PAUSE_DIM_FADE_EN
  localparam logic [TW-1:0] T_FADE = TW'(FADE_INTERVAL - 1);
`endif
  localparam logic [1:0] STEPS = 2'(DIM_STEPS);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    WAIT   = 2'd1,
`ifdef PAUSE_DIM_FADE_EN
    FADE   = 2'd3,
`endif
    DIMMED = 2'd2
  } state_t;

  state_t             state, state_n;
  logic [TW-1:0]      timer, timer_n;
  logic [1:0]         dim, dim_n;
  logic               btn_q, armed;
  logic               up, up_n, rise;
  logic               pause_q;
  logic [CW-1:0]      rgb_q;
  logic [NUM_SRC-1:0] req;
  logic [RW-1:0]      r;
  logic [GW-1:0]      g;
  logic [BW-1:0]      b;

  assign req = bus.pause_req;
  assign r   = bus.rgb_in[CW-1 -: RW];
  assign g   = bus.rgb_in[GW+BW-1 -: GW];
  assign b   = bus.rgb_in[BW-1:0];

  // armed blocks a button held high across reset release
  assign rise = bus.user_btn & ~btn_q & armed;
  assign up_n = up ^ rise;

  always_comb begin
    state_n = state;
    timer_n = timer;
    dim_n   = dim;
    if (!up_n) begin
      state_n = RUN;
      timer_n = '0;
      dim_n   = '0;
    end else begin
      unique case (state)
        RUN: begin
          state_n = WAIT;
          timer_n = '0;
          dim_n   = '0;
        end
        WAIT: begin
          if (timer == T_DIM) begin
            timer_n = '0;
`ifdef PAUSE_DIM_FADE_EN
            dim_n   = 2'd1;
            state_n = (DIM_STEPS == 1) ? DIMMED : FADE;
`else
            dim_n   = STEPS;
            state_n = DIMMED;
`endif
          end else begin
            timer_n = timer + 1'b1;
          end
        end
`ifdef PAUSE_DIM_FADE_EN
        FADE: begin
          if (timer == T_FADE) begin
            timer_n = '0;
            dim_n   = dim + 2'd1;
            if (dim_n == STEPS) state_n = DIMMED;
          end else begin
            timer_n = timer + 1'b1;
          end
        end
`endif
        DIMMED: dim_n = STEPS;
        default: begin
          state_n = RUN;
          timer_n = '0;
          dim_n   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= RUN;
      timer   <= '0;
      dim     <= '0;
      btn_q   <= 1'b0;
      armed   <= 1'b0;
      up      <= 1'b0;
      pause_q <= 1'b0;
      rgb_q   <= '0;
    end else begin
      state   <= state_n;
      timer   <= timer_n;
      dim     <= dim_n;
      btn_q   <= bus.user_btn;
      armed   <= armed | ~bus.user_btn;
      up      <= up_n;
      pause_q <= (|req) | up_n
               | (bus.osd_open & bus.osd_pause_en);
      rgb_q   <= {r >> dim, g >> dim, b >> dim};
    end
  end

  assign bus.pause       = pause_q;
  assign bus.user_paused = up;
  assign bus.dim_level   = dim;
  assign bus.rgb_out     = rgb_q;
endmodule

// File: tb/tb_pause_dim_ctrl.sv
// Directed bench for pause_dim_ctrl with an expectation queue.
// Works for both fade-on and fade-off builds.
module tb_pause_dim_ctrl;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   total = 0;
  int   passed = 0;
  logic [1:0] prev_dim = 2'd0;

  typedef struct packed {
    logic       p;
    logic       u;
    logic [1:0] d;
    logic [7:0] rgb;
  } exp_t;

  exp_t q[$];

  pause_dim_ctrl_if #(.NUM_SRC(2), .RW(3), .GW(3), .BW(2)) bus ();

  pause_dim_ctrl #(
    .NUM_SRC(2), .DIM_TIMEOUT(10), .FADE_INTERVAL(4),
    .DIM_STEPS(2), .RW(3), .GW(3), .BW(2)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] shade(input logic [7:0] x,
                                       input logic [1:0] d);
    logic [2:0] rr, gg;
    logic [1:0] bb;
    rr = x[7:5] >> d;
    gg = x[4:2] >> d;
    bb = x[1:0] >> d;
    return {rr, gg, bb};
  endfunction

  function automatic logic [1:0] wait_dim(input int i);
`ifdef PAUSE_DIM_FADE_EN
    if (i < 10) return 2'd0;
    if (i < 14) return 2'd1;
    return 2'd2;
`else
    if (i < 10) return 2'd0;
    return 2'd2;
`endif
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs,
                     input logic [7:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic step(input string tag, input logic ep,
                      input logic eu, input logic [1:0] ed);
    exp_t e, g;
    e.p   = ep;
    e.u   = eu;
    e.d   = ed;
    e.rgb = reset ? 8'h00 : shade(bus.rgb_in, prev_dim);
    q.push_back(e);
    @(posedge clk);
    #1;
    g = q.pop_front();
    chk({tag, ".pause"}, 8'(bus.pause), 8'(g.p));
    chk({tag, ".user"}, 8'(bus.user_paused), 8'(g.u));
    chk({tag, ".dim"}, 8'(bus.dim_level), 8'(g.d));
    chk({tag, ".rgb"}, bus.rgb_out, g.rgb);
    prev_dim = ed;
  endtask

  initial begin
    bus.pause_req    = 2'b00;
    bus.user_btn     = 1'b0;
    bus.osd_open     = 1'b0;
    bus.osd_pause_en = 1'b0;
    bus.rgb_in       = 8'hFF;

    step("rst0", 0, 0, 2'd0);
    step("rst1", 0, 0, 2'd0);
    reset = 1'b0;
    step("idle", 0, 0, 2'd0);

    bus.osd_open = 1'b1;
    step("osd_noen", 0, 0, 2'd0);
    bus.osd_pause_en = 1'b1;
    step("osd_en", 1, 0, 2'd0);
    bus.osd_open = 1'b0;
    step("osd_close", 0, 0, 2'd0);
    bus.osd_pause_en = 1'b0;

    bus.pause_req = 2'b01;
    for (int i = 0; i < 50; i++) begin
      bus.rgb_in = 8'($urandom);
      step("ext_req", 1, 0, 2'd0);
    end
    bus.pause_req = 2'b00;
    step("ext_off", 0, 0, 2'd0);

    bus.user_btn = 1'b1;
    step("pulse1", 1, 1, 2'd0);
    bus.user_btn = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      bus.rgb_in = 8'($urandom);
      step("dimming", 1, 1, wait_dim(i));
    end
    bus.rgb_in = 8'hFF;
    step("dim_ff", 1, 1, 2'd2);
    chk("rgb_24", bus.rgb_out, 8'h24);

    bus.user_btn = 1'b1;
    step("unpause", 0, 0, 2'd0);
    bus.user_btn = 1'b0;
    step("run", 0, 0, 2'd0);

    bus.user_btn = 1'b1;
    step("pulse2", 1, 1, 2'd0);
    bus.user_btn = 1'b0;
    for (int i = 1; i <= 9; i++)
      step("wait2", 1, 1, 2'd0);
    bus.user_btn = 1'b1;
    step("tog_at_tmo", 0, 0, 2'd0);
    bus.user_btn = 1'b0;
    step("run2", 0, 0, 2'd0);

    bus.user_btn = 1'b1;
    step("pulse3", 1, 1, 2'd0);
    bus.user_btn = 1'b0;
    for (int i = 1; i <= 11; i++) begin
      bus.rgb_in = 8'($urandom);
      step("fade3", 1, 1, wait_dim(i));
    end
    bus.user_btn = 1'b1;
    reset = 1'b1;
    step("rst_mid", 0, 0, 2'd0);
    reset = 1'b0;
    step("held_btn", 0, 0, 2'd0);
    bus.user_btn = 1'b0;
    step("btn_low", 0, 0, 2'd0);
    bus.user_btn = 1'b1;
    step("pulse4", 1, 1, 2'd0);
    bus.user_btn = 1'b0;
    step("wait4", 1, 1, 2'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
